// File: rtl/vec_mux_arbiter.sv
// vec_mux_arbiter: two-requester arbiter that drives the select of a 9x9-bit
// signed vector mux. Grants run for bursts of up to BURST beats and then
// rotate to the other requester. A beat is out_valid & out_ready.
// Optional build macro VEC_MUX_ARBITER_STATS_EN adds saturating per-requester
// beat counters on cnt0/cnt1. Without the macro, cnt0/cnt1 read as zero.
module vec_mux_arbiter #(
   parameter int unsigned BURST = 4   // beats per grant before rotation, 1..255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req0,
   input  logic        req1,
   input  logic        out_ready,
   output logic        sel,
   output logic        out_valid,
   output logic        ack0,
   output logic        ack1,
   output logic        busy,
   output logic [15:0] cnt0,
   output logic [15:0] cnt1
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_t;

   localparam logic [7:0] LP_LAST_BEAT = 8'(BURST - 1);

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_beat_cnt;
   logic       r_last;       // requester served by the most recent grant
   logic       w_beat;
   logic       w_release;

   // State register: grant state, in-burst beat counter, last-served requester
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of the others.
      if (!reset_n) begin
         r_state    <= IDLE;
         r_beat_cnt <= 8'd0;
         r_last     <= 1'b1;   // requester 0 wins the first tie
      end else begin
         r_state <= w_next;
         if (w_release) begin
            r_beat_cnt <= 8'd0;
            r_last     <= (r_state == G1);
         end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
         end
      end
   end

   // Next-state logic: tie-break in IDLE, release and hand-over in G0/G1
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latch).
      w_next    = r_state;
      w_release = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (req0 && req1)
               w_next = r_last ? G0 : G1;
            else if (req0)
               w_next = G0;
            else if (req1)
               w_next = G1;
         end
         G0: begin
            // A dropped request ends the grant without a beat
            w_release = (w_beat && (r_beat_cnt == LP_LAST_BEAT)) || !req0;
            if (w_release) begin
               if (req1)
                  w_next = G1;
               else if (req0)
                  w_next = G0;
               else
                  w_next = IDLE;
            end
         end
         G1: begin
            w_release = (w_beat && (r_beat_cnt == LP_LAST_BEAT)) || !req1;
            if (w_release) begin
               if (req0)
                  w_next = G0;
               else if (req1)
                  w_next = G1;
               else
                  w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Output logic: mux select, valid, beat and acknowledge pulses
   always_comb begin
      sel       = (r_state == G1);
      busy      = (r_state != IDLE);
      out_valid = ((r_state == G0) && req0) || ((r_state == G1) && req1);
      w_beat    = out_valid && out_ready;
      // A reset cycle abandons the burst, so no vector is acknowledged in it
      ack0      = w_beat && (r_state == G0) && reset_n;
      ack1      = w_beat && (r_state == G1) && reset_n;
   end

`ifdef VEC_MUX_ARBITER_STATS_EN
   logic [15:0] r_cnt0;
   logic [15:0] r_cnt1;

   // Statistics: saturating beat counts per requester, cleared only by reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt0 <= 16'd0;
         r_cnt1 <= 16'd0;
      end else begin
         if (ack0 && (r_cnt0 != 16'hFFFF))
            r_cnt0 <= r_cnt0 + 16'd1;
         if (ack1 && (r_cnt1 != 16'hFFFF))
            r_cnt1 <= r_cnt1 + 16'd1;
      end
   end

   assign cnt0 = r_cnt0;
   assign cnt1 = r_cnt1;
`else
   assign cnt0 = 16'd0;
   assign cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_vec_mux_arbiter.sv
// Directed bench for vec_mux_arbiter (BURST=4 main instance, BURST=1 side
// instance for the alternate-every-beat case). Honors
// VEC_MUX_ARBITER_STATS_EN for the expected cnt0/cnt1 values.
module tb_vec_mux_arbiter;

`ifdef VEC_MUX_ARBITER_STATS_EN
   localparam bit LP_STATS = 1'b1;
`else
   localparam bit LP_STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req0 = 1'b0;
   logic        req1 = 1'b0;
   logic        out_ready = 1'b0;

   logic        sel, out_valid, ack0, ack1, busy;
   logic [15:0] cnt0, cnt1;
   logic        sel_b1, ov_b1, a0_b1, a1_b1, busy_b1;
   logic [15:0] c0_b1, c1_b1;

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] e_c0 = 16'd0;
   logic [15:0] e_c1 = 16'd0;

   always #5 clk = ~clk;

   vec_mux_arbiter #(.BURST(4)) u_dut (
      .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1),
      .out_ready(out_ready), .sel(sel), .out_valid(out_valid),
      .ack0(ack0), .ack1(ack1), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
   );

   vec_mux_arbiter #(.BURST(1)) u_dut_b1 (
      .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1),
      .out_ready(out_ready), .sel(sel_b1), .out_valid(ov_b1),
      .ack0(a0_b1), .ack1(a1_b1), .busy(busy_b1), .cnt0(c0_b1), .cnt1(c1_b1)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks the main instance mid-cycle, then advances one clock and updates
   // the expected statistics from the acks this cycle should have produced.
   task automatic cyc(input string tag, input logic e_sel, input logic e_valid,
                      input logic e_a0, input logic e_a1, input logic e_busy);
      #1;
      chk({tag, ".sel"},       16'(sel),       16'(e_sel));
      chk({tag, ".out_valid"}, 16'(out_valid), 16'(e_valid));
      chk({tag, ".ack0"},      16'(ack0),      16'(e_a0));
      chk({tag, ".ack1"},      16'(ack1),      16'(e_a1));
      chk({tag, ".busy"},      16'(busy),      16'(e_busy));
      chk({tag, ".cnt0"},      cnt0,           LP_STATS ? e_c0 : 16'd0);
      chk({tag, ".cnt1"},      cnt1,           LP_STATS ? e_c1 : 16'd0);
      @(posedge clk);
      if (!reset_n) begin
         e_c0 = 16'd0;
         e_c1 = 16'd0;
      end else begin
         if (e_a0 && (e_c0 != 16'hFFFF)) e_c0 = e_c0 + 16'd1;
         if (e_a1 && (e_c1 != 16'hFFFF)) e_c1 = e_c1 + 16'd1;
      end
      #1;
   endtask

   initial begin
      // Two reset cycles with both requests pending
      reset_n = 1'b0; req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      cyc("rst", 0, 0, 0, 0, 0);

      // Requester 0 alone: one IDLE cycle, then nine back-to-back acks
      reset_n = 1'b1; req1 = 1'b0;
      cyc("r0_idle", 0, 0, 0, 0, 0);
      for (int i = 2; i <= 10; i++) cyc("r0_beat", 0, 1, 1, 0, 1);
      req0 = 1'b0;
      cyc("r0_drop", 0, 0, 0, 0, 1);
      cyc("r0_idle2", 0, 0, 0, 0, 0);

      // Reset, then both requesting: 4/4 rotation; BURST=1 alternates per beat
      reset_n = 1'b0;
      cyc("rst2", 0, 0, 0, 0, 0);
      reset_n = 1'b1; req0 = 1'b1; req1 = 1'b1;
      cyc("both_idle", 0, 0, 0, 0, 0);
      for (int k = 0; k < 12; k++) begin
         logic s;
         s = 1'(k / 4);
         #1;
         chk("b1.sel",  16'(sel_b1), 16'(k % 2));
         chk("b1.ack0", 16'(a0_b1),  16'((k + 1) % 2));
         chk("b1.ack1", 16'(a1_b1),  16'(k % 2));
         cyc("both", s, 1, !s, s, 1);
      end
      chk("b1.cnt0", c0_b1, LP_STATS ? 16'd6 : 16'd0);
      chk("b1.cnt1", c1_b1, LP_STATS ? 16'd6 : 16'd0);
      chk("b1.busy", 16'(busy_b1), 16'd1);
      chk("b1.valid", 16'(ov_b1), 16'd1);

      // Stall in G1 after one beat: grant and count frozen, then 3 more beats
      cyc("g1_b1", 1, 1, 0, 1, 1);
      out_ready = 1'b0;
      repeat (3) cyc("g1_stall", 1, 1, 0, 0, 1);
      out_ready = 1'b1;
      repeat (3) cyc("g1_resume", 1, 1, 0, 1, 1);
      cyc("g0_after", 0, 1, 1, 0, 1);

      // Requester 1 drops after two beats: immediate hand-over to G0
      repeat (3) cyc("g0_rest", 0, 1, 1, 0, 1);
      repeat (2) cyc("g1_two", 1, 1, 0, 1, 1);
      req1 = 1'b0;
      cyc("g1_drop", 1, 0, 0, 0, 1);
      cyc("g0_switch", 0, 1, 1, 0, 1);

      // Reset on beat 2 of a G0 burst: no ack, IDLE, then a full G0 burst
      req1 = 1'b1; reset_n = 1'b0;
      cyc("rst_mid", 0, 1, 0, 0, 1);
      reset_n = 1'b1;
      cyc("rst_idle", 0, 0, 0, 0, 0);
      repeat (4) cyc("rst_g0", 0, 1, 1, 0, 1);
      cyc("rst_g1", 1, 1, 0, 1, 1);

`ifdef VEC_MUX_ARBITER_STATS_EN
      // Saturation: more than 65535 further requester-0 beats
      req1 = 1'b0;
      repeat (65536) @(posedge clk);
      #1;
      e_c0 = 16'hFFFF;
      cyc("sat", 0, 1, 1, 0, 1);
      cyc("sat_hold", 0, 1, 1, 0, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vec_mux_arbiter.md
VEC_MUX_ARBITER -- requirements
Module: vec_mux_arbiter

Interface
REQ-001 Parameter BURST, default 4, max beats per grant before rotation; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 req0  input  1  requester 0 (vector source on mux d0) has a vector pending.
REQ-005 req1  input  1  requester 1 (vector source on mux d1) has a vector pending.
REQ-006 out_ready  input  1  downstream vector consumer accepts this cycle.
REQ-007 sel  output  1  select driving the 9x9-bit signed vector mux s input; 0=d0, 1=d1.
REQ-008 out_valid  output  1  selected vector is valid downstream.
REQ-009 ack0  output  1  one-cycle pulse: requester 0 vector consumed.
REQ-010 ack1  output  1  one-cycle pulse: requester 1 vector consumed.
REQ-011 busy  output  1  high whenever a grant is held.
REQ-012 cnt0  output  16  beats served to requester 0 (stats build only).
REQ-013 cnt1  output  16  beats served to requester 1 (stats build only).

Function
REQ-014 FSM states IDLE, G0, G1 shall be registered; sel=1 only in G1; busy=1 in G0/G1.
REQ-015 out_valid shall be (G0 & req0) | (G1 & req1), combinational from state and req.
REQ-016 Beat = out_valid & out_ready; ack0 = beat & G0; ack1 = beat & G1; never both high.
REQ-017 IDLE: only reqX high -> GX next cycle; both high -> grant the requester not in register last; neither -> stay IDLE; no beat in IDLE cycles.
REQ-018 8-bit beat counter shall increment on each beat and hold when out_ready=0 (stall holds sel, state, counter).
REQ-019 Release in GX when (beat and counter==BURST-1) or reqX==0; on release last<=X, counter<=0.
REQ-020 On release: other req high -> other grant next cycle, no IDLE bubble; else own req high (burst end only) -> stay GX with counter cleared; else IDLE.
REQ-021 Requester X shall hold reqX until ackX; dropping reqX before ack is treated as release with no beat.
REQ-022 BURST=1 shall alternate grant every beat when both request.

Reset
REQ-023 reset_n=0 at a clock edge: state<=IDLE, counter<=0, last<=1 (requester 0 wins first tie), cnt0/cnt1<=0.
REQ-024 Outputs after reset edge: sel=0, out_valid=0, ack0=ack1=0, busy=0; reset mid-burst abandons burst with no ack that cycle.

Configuration
REQ-025 Macro VEC_MUX_ARBITER_STATS_EN defined: cnt0/cnt1 increment on ack0/ack1, saturate at 16'hFFFF, clear only on reset.
REQ-026 Macro undefined: counters not built, cnt0/cnt1 tied to 0; all other behaviour identical.

Verification (BURST=4)
REQ-027 reset_n=0 two cycles, req0=req1=1 -> sel=0, out_valid=0, busy=0, acks 0, cnt0=cnt1=0.
REQ-028 req0 only, out_ready=1, 10 cycles after reset -> cycle 1 IDLE->G0, ack0 high cycles 2..10 continuously (burst re-grant, no bubble), sel=0 throughout.
REQ-029 req0=req1=1, out_ready=1 -> 4 ack0, then sel=1 with 4 ack1 starting the very next cycle, repeating; with STATS_EN cnt0=4, cnt1=4 after 8 beats.
REQ-030 In G1 after 1 beat, out_ready=0 for 3 cycles -> sel=1 held, no ack, counter frozen at 1; resume -> exactly 3 more ack1 before switch.
REQ-031 In G1 after 2 beats, req1 drops, req0=1 -> next cycle G0, sel=0, ack0 on that cycle if out_ready=1.
REQ-032 reset_n=0 for one cycle at beat 2 of G0 burst, both req high -> IDLE, then G0 (last=1) with full 4-beat burst; STATS_EN saturation: preload via 65535 beats -> cnt0 stays 16'hFFFF.
